// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the execute-stage ALU: widths, op encodings, FSM states
// and small decode helpers used by the top level.
package alu_muldiv_pkg;

    localparam int CPU_WIDTH      = 32;
    localparam int ALU_CTRL_WIDTH = 5;

    typedef enum logic [4:0] {
        OP_AND    = 5'd0,
        OP_OR     = 5'd1,
        OP_ADD    = 5'd2,
        OP_SUB    = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // M-extension ops occupy 16..23
    function automatic logic is_mop(input logic [4:0] op);
        return op[4] & ~op[3];
    endfunction

    function automatic logic op_signed_a(input logic [4:0] op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: op_signed_a = 1'b1;
            default:                                    op_signed_a = 1'b0;
        endcase
    endfunction

    function automatic logic op_signed_b(input logic [4:0] op);
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: op_signed_b = 1'b1;
            default:                         op_signed_b = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iterative datapath: one shift-add (multiply) or restoring-subtract
// (divide) step per cycle on a 2*XLEN accumulator holding unsigned magnitudes.
module alu_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc,
    output logic              last
);

    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]     cnt_r;
    logic [XLEN-1:0]   opnd_r;
    logic              div_r;
    logic [2*XLEN-1:0] acc_r;
    logic [2*XLEN-1:0] next_s;
    logic [XLEN:0]     sum_s;
    logic [XLEN:0]     shi_s;
    logic [XLEN:0]     diff_s;

    // Next accumulator value; divide keeps remainder in the high half, quotient in the low half
    always_comb begin
        sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_r[0]}} & opnd_r};
        shi_s  = acc_r[2*XLEN-1:XLEN-1];
        diff_s = shi_s - {1'b0, opnd_r};
        next_s = '0;
        if (div_r) begin
            if (shi_s >= {1'b0, opnd_r}) begin
                next_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                next_s = {shi_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            next_s = {sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Accumulator, step operand and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= '0;
            opnd_r <= '0;
            div_r  <= 1'b0;
            cnt_r  <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (load) begin
            acc_r  <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            opnd_r <= is_div ? b_mag : a_mag;
            div_r  <= is_div;
            cnt_r  <= CW'(XLEN - 1);
        end else if (step) begin
            acc_r <= next_s;
            if (cnt_r != '0) begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end

    assign acc  = acc_r;
    assign last = (cnt_r == '0);

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with RV32M multiply/divide behind a valid/ready handshake.
// Simple ops finish in one cycle; M ops iterate XLEN steps then a sign-fix cycle.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN   = CPU_WIDTH,
    parameter int CTRL_W = ALU_CTRL_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   data_in_1,
    input  logic [XLEN-1:0]   data_in_2,
    input  logic [CTRL_W-1:0] alu_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_result,
    output logic              zero,
    output logic              busy
);

    localparam int SHW = $clog2(XLEN);

    state_e            state_r;
    logic [4:0]        op_s;
    logic [4:0]        op_r;
    logic              accept_s;
    logic              sign_a_s;
    logic              sign_b_s;
    logic              last_s;
    logic              neg_r;
    logic              rem_neg_r;
    logic              div_zero_r;
    logic [SHW-1:0]    shamt_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic [XLEN-1:0]   simple_s;
    logic [XLEN-1:0]   fix_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [2*XLEN-1:0] acc_s;
    logic [2*XLEN-1:0] prod_s;

    assign op_s     = 5'(alu_ctrl);
    assign in_ready = (state_r == S_IDLE) | ((state_r == S_DONE) & out_ready);
    assign accept_s = in_valid & in_ready & ~flush;
    assign sign_a_s = op_signed_a(op_s) & data_in_1[XLEN-1];
    assign sign_b_s = op_signed_b(op_s) & data_in_2[XLEN-1];
    assign a_mag_s  = sign_a_s ? -data_in_1 : data_in_1;
    assign b_mag_s  = sign_b_s ? -data_in_2 : data_in_2;
    assign shamt_s  = data_in_2[SHW-1:0];

    alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (flush),
        .load   (accept_s & is_mop(op_s)),
        .step   (state_r == S_ITER),
        .is_div (op_s[2]),
        .a_mag  (a_mag_s),
        .b_mag  (b_mag_s),
        .acc    (acc_s),
        .last   (last_s)
    );

    // Single-cycle ops; unknown codes produce zero
    always_comb begin
        simple_s = '0;
        case (op_s)
            OP_AND:  simple_s = data_in_1 & data_in_2;
            OP_OR:   simple_s = data_in_1 | data_in_2;
            OP_XOR:  simple_s = data_in_1 ^ data_in_2;
            OP_ADD:  simple_s = data_in_1 + data_in_2;
            OP_SUB:  simple_s = data_in_1 + ~data_in_2 + XLEN'(1);
            OP_SLL:  simple_s = data_in_1 << shamt_s;
            OP_SRL:  simple_s = data_in_1 >> shamt_s;
            OP_SRA:  simple_s = $unsigned($signed(data_in_1) >>> shamt_s);
            OP_SLT:  simple_s = {{(XLEN-1){1'b0}}, ($signed(data_in_1) < $signed(data_in_2))};
            OP_SLTU: simple_s = {{(XLEN-1){1'b0}}, (data_in_1 < data_in_2)};
            default: simple_s = '0;
        endcase
    end

    // Sign correction and half/quotient/remainder select for the FIX cycle
    always_comb begin
        prod_s = neg_r ? -acc_s : acc_s;
        quo_s  = acc_s[XLEN-1:0];
        rem_s  = acc_s[2*XLEN-1:XLEN];
        fix_s  = '0;
        case (op_r)
            OP_MUL:                       fix_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_s = div_zero_r ? '1 : (neg_r ? -quo_s : quo_s);
            OP_REM, OP_REMU:              fix_s = rem_neg_r ? -rem_s : rem_s;
            default:                      fix_s = '0;
        endcase
    end

    // Control FSM with registered result, zero, valid and busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            out_valid  <= 1'b0;
            alu_result <= '0;
            zero       <= 1'b1;
            busy       <= 1'b0;
            op_r       <= 5'd0;
            neg_r      <= 1'b0;
            rem_neg_r  <= 1'b0;
            div_zero_r <= 1'b0;
        end else if (flush) begin
            state_r   <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (accept_s && is_mop(op_s)) begin
                        state_r    <= S_ITER;
                        out_valid  <= 1'b0;
                        busy       <= 1'b1;
                        op_r       <= op_s;
                        neg_r      <= sign_a_s ^ sign_b_s;
                        rem_neg_r  <= sign_a_s;
                        div_zero_r <= (data_in_2 == '0);
                    end else if (accept_s) begin
                        state_r    <= S_DONE;
                        out_valid  <= 1'b1;
                        alu_result <= simple_s;
                        zero       <= (simple_s == '0);
                    end else if ((state_r == S_DONE) && out_ready) begin
                        state_r   <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                S_ITER: begin
                    if (last_s) begin
                        state_r <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_r    <= S_DONE;
                    busy       <= 1'b0;
                    out_valid  <= 1'b1;
                    alu_result <= fix_s;
                    zero       <= (fix_s == '0);
                end
                default: begin
                    state_r   <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
